// File: rtl/dcsformer_pkg.sv
// Shared types and frame-size defaults for the DCSformer host controller.
package dcsformer_pkg;

  typedef enum logic [2:0] {
    LOAD,
    SEND_I,
    WAIT_W,
    SEND_W,
    WAIT_O,
    RECV_O,
    DRAIN
  } state_e;

  localparam int N_IN_DEF    = 128;
  localparam int N_W_DEF     = 8;
  localparam int N_OUT_DEF   = 8;
  localparam int TIMEOUT_DEF = 1024;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

endpackage

// File: rtl/dcsformer_host_if.sv
// Bus bundle between the host controller, the upstream byte source, the core and the result sink.
interface dcsformer_host_if;

  logic                 s_valid;
  logic                 s_ready;
  dcsformer_pkg::byte_t s_data;
  logic                 i_valid;
  dcsformer_pkg::byte_t i_data;
  logic                 w_ready;
  logic                 w_valid;
  dcsformer_pkg::byte_t w_data;
  logic                 o_valid;
  dcsformer_pkg::word_t o_data;
  logic                 m_valid;
  logic                 m_ready;
  dcsformer_pkg::word_t m_data;
  logic                 m_last;

  modport master (
    input  s_valid, s_data, w_ready, o_valid, o_data, m_ready,
    output s_ready, i_valid, i_data, w_valid, w_data, m_valid, m_data, m_last
  );

  modport slave (
    output s_valid, s_data, w_ready, o_valid, o_data, m_ready,
    input  s_ready, i_valid, i_data, w_valid, w_data, m_valid, m_data, m_last
  );

endinterface

// File: rtl/dcsformer_host_timer.sv
// Wait-state cycle counter: cleared while not waiting, counts while enabled, saturates at LIMIT.
module dcsformer_host_timer #(
  parameter int unsigned      WIDTH = 10,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = en && (count_q == LIMIT);

endmodule

// File: rtl/dcsformer_host.sv
// Host-side sequencer for the DCSformer core: buffers a frame, streams inputs and weights
// to the core, collects its result words and drains them downstream.
module dcsformer_host
  import dcsformer_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int N_W     = N_W_DEF,
  parameter int N_OUT   = N_OUT_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  dcsformer_host_if.master bus,
  output logic             busy,
  output logic             err
);

  localparam int N_FRAME = N_IN + N_W;
  localparam int CW      = $clog2(N_FRAME + 1);
  localparam int OW      = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int TW      = $clog2(TIMEOUT);

  localparam logic [CW-1:0] LAST_LD  = CW'(N_FRAME - 1);
  localparam logic [CW-1:0] N_IN_C   = CW'(N_IN);
  localparam logic [CW-1:0] N_W_C    = CW'(N_W);
  localparam logic [CW-1:0] LAST_OUT = CW'(N_OUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s_ready_q, s_ready_d;
  logic          i_valid_q, i_valid_d;
  byte_t         i_data_q, i_data_d;
  logic          w_valid_q, w_valid_d;
  byte_t         w_data_q, w_data_d;
  logic          err_q, err_d;
  logic          frame_we, res_we;
  logic          waiting, expired;

  byte_t frame_q [N_FRAME];
  word_t res_q   [N_OUT];

  assign waiting = (state_q == WAIT_W) || (state_q == WAIT_O);

  dcsformer_host_timer #(
    .WIDTH (TW),
    .LIMIT (TW'(TIMEOUT - 1))
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!waiting),
    .en      (waiting),
    .expired (expired)
  );

  // Core-side outputs are loaded from the byte the state will present next cycle,
  // so i_valid/w_valid coincide exactly with SEND_I/SEND_W occupancy.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    i_valid_d = 1'b0;
    i_data_d  = '0;
    w_valid_d = 1'b0;
    w_data_d  = '0;
    err_d     = err_q;
    frame_we  = 1'b0;
    res_we    = 1'b0;

    unique case (state_q)
      LOAD: begin
        if (bus.s_valid && s_ready_q) begin
          frame_we = 1'b1;
          if (cnt_q == LAST_LD) begin
            state_d   = SEND_I;
            cnt_d     = CW'(1);
            i_valid_d = 1'b1;
            i_data_d  = frame_q[0];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SEND_I: begin
        if (cnt_q == N_IN_C) begin
          state_d = WAIT_W;
          cnt_d   = '0;
        end else begin
          i_valid_d = 1'b1;
          i_data_d  = frame_q[cnt_q];
          cnt_d     = cnt_q + 1'b1;
        end
      end
      WAIT_W: begin
        if (bus.w_ready) begin
          state_d   = SEND_W;
          cnt_d     = CW'(1);
          w_valid_d = 1'b1;
          w_data_d  = frame_q[N_IN_C];
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      SEND_W: begin
        if (cnt_q == N_W_C) begin
          state_d = WAIT_O;
          cnt_d   = '0;
        end else begin
          w_valid_d = 1'b1;
          w_data_d  = frame_q[N_IN_C + cnt_q];
          cnt_d     = cnt_q + 1'b1;
        end
      end
      WAIT_O: begin
        if (bus.o_valid) begin
          res_we  = 1'b1;
          state_d = RECV_O;
          cnt_d   = CW'(1);
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      RECV_O: begin
        if (bus.o_valid) begin
          res_we = 1'b1;
          if (cnt_q == LAST_OUT) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (bus.m_ready) begin
          if (cnt_q == LAST_OUT) begin
            state_d = LOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase

    s_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
      i_valid_q <= 1'b0;
      i_data_q  <= '0;
      w_valid_q <= 1'b0;
      w_data_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
      i_valid_q <= i_valid_d;
      i_data_q  <= i_data_d;
      w_valid_q <= w_valid_d;
      w_data_q  <= w_data_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (frame_we) begin
      frame_q[cnt_q] <= bus.s_data;
    end
    if (res_we) begin
      res_q[cnt_q[OW-1:0]] <= bus.o_data;
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.i_valid = i_valid_q;
  assign bus.i_data  = i_data_q;
  assign bus.w_valid = w_valid_q;
  assign bus.w_data  = w_data_q;
  assign bus.m_valid = (state_q == DRAIN);
  assign bus.m_data  = (state_q == DRAIN) ? res_q[cnt_q[OW-1:0]] : '0;
  assign bus.m_last  = (state_q == DRAIN) && (cnt_q == LAST_OUT);
  assign busy        = (state_q != LOAD);
  assign err         = err_q;

endmodule

// File: tb/tb_dcsformer_host.sv
// Directed bench for dcsformer_host with a scripted core model and scoreboard queues.
module tb_dcsformer_host;
  import dcsformer_pkg::*;

  logic clk;
  logic rst_n;
  logic busy;
  logic err;

  int checks = 0;
  int errors = 0;

  byte_t iq[$];
  byte_t wq[$];
  word_t mq[$];
  byte_t wstage[8];

  dcsformer_host_if bus();

  dcsformer_host #(
    .N_IN    (128),
    .N_W     (8),
    .N_OUT   (8),
    .TIMEOUT (1024)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Core-side stream monitor: every i/w beat must match the next scoreboard byte.
  always @(negedge clk) begin
    if (bus.i_valid === 1'b1) begin
      if (iq.size() != 0) chk("i_data", 32'(bus.i_data), 32'(iq.pop_front()));
      else chk("i_extra", 32'(bus.i_data), 32'h100);
    end else begin
      chk("i_idle", 32'(bus.i_data), 32'h0);
    end
    if (bus.w_valid === 1'b1) begin
      if (wq.size() != 0) chk("w_data", 32'(bus.w_data), 32'(wq.pop_front()));
      else chk("w_extra", 32'(bus.w_data), 32'h100);
    end else begin
      chk("w_idle", 32'(bus.w_data), 32'h0);
    end
  end

  task automatic load_frame(input byte_t base, input bit toggle, output int c);
    int n;
    bit acc;
    byte_t b;
    n = 0;
    c = 0;
    while (n < 136 && c < 600) begin
      b = byte_t'(32'(base) + n);
      bus.s_valid = toggle ? c[0] : 1'b1;
      bus.s_data  = b;
      acc = bus.s_valid && (bus.s_ready === 1'b1);
      if (acc) begin
        if (n < 128) iq.push_back(b);
        else wstage[n-128] = b;
        n++;
      end
      c++;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    chk("load_beats", 32'(n), 32'd136);
  endtask

  task automatic send_i(input bit spurious, output int n);
    chk("i_first", 32'(bus.i_valid), 32'd1);
    chk("s_ready_drop", 32'(bus.s_ready), 32'd0);
    n = 1;
    if (spurious) begin
      bus.o_valid = 1'b1;
      bus.o_data  = 32'hDEAD_BEEF;
    end
    while (bus.i_valid === 1'b1 && n < 200) begin
      @(negedge clk);
      bus.o_valid = 1'b0;
      bus.o_data  = '0;
      if (bus.i_valid === 1'b1) n++;
    end
    bus.o_valid = 1'b0;
    chk("i_len", 32'(n), 32'd128);
  endtask

  task automatic core_w(input int delay);
    int n;
    repeat (delay) @(negedge clk);
    foreach (wstage[k]) wq.push_back(wstage[k]);
    bus.w_ready = 1'b1;
    chk("w_pre", 32'(bus.w_valid), 32'd0);
    @(negedge clk);
    bus.w_ready = 1'b0;
    chk("w_first", 32'(bus.w_valid), 32'd1);
    n = 1;
    while (bus.w_valid === 1'b1 && n < 20) begin
      @(negedge clk);
      if (bus.w_valid === 1'b1) n++;
    end
    chk("w_len", 32'(n), 32'd8);
  endtask

  task automatic core_o(input word_t salt, input bit gap);
    word_t w;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      if (gap && k == 5) begin
        bus.o_valid = 1'b0;
        @(negedge clk);
      end
      w = (32'(k) * 32'h0101_0101) ^ salt;
      bus.o_valid = 1'b1;
      bus.o_data  = w;
      mq.push_back(w);
      @(negedge clk);
    end
    bus.o_valid = 1'b0;
    bus.o_data  = '0;
  endtask

  task automatic drain(input int stall_word);
    int idx, cyc, stall;
    word_t e;
    idx = 0;
    cyc = 0;
    stall = 0;
    while (idx < 8 && cyc < 100) begin
      chk("m_valid", 32'(bus.m_valid), 32'd1);
      if (idx == stall_word && stall < 5) begin
        bus.m_ready = 1'b0;
        stall++;
        chk("m_hold", bus.m_data, (mq.size() != 0) ? mq[0] : 32'hFFFF_FFFF);
      end else begin
        bus.m_ready = 1'b1;
        e = (mq.size() != 0) ? mq.pop_front() : 32'hFFFF_FFFF;
        chk("m_data", bus.m_data, e);
        chk("m_last", 32'(bus.m_last), 32'(idx == 7));
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.m_ready = 1'b0;
    chk("drain_words", 32'(idx), 32'd8);
    chk("next_s_ready", 32'(bus.s_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_m_valid", 32'(bus.m_valid), 32'd0);
  endtask

  task automatic full_frame(input byte_t base, input bit toggle, input bit spurious,
                            input int wdelay, input bit gap, input int stall_word,
                            input word_t salt);
    int c, n;
    load_frame(base, toggle, c);
    chk("load_cycles", 32'(c), toggle ? 32'd272 : 32'd136);
    send_i(spurious, n);
    core_w(wdelay);
    core_o(salt, gap);
    drain(stall_word);
  endtask

  initial begin
    int c, n;
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.w_ready = 1'b0;
    bus.o_valid = 1'b0;
    bus.o_data  = '0;
    bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_i_valid", 32'(bus.i_valid), 32'd0);
    chk("rst_w_valid", 32'(bus.w_valid), 32'd0);
    chk("rst_w_data", 32'(bus.w_data), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data", bus.m_data, 32'd0);
    chk("rst_m_last", 32'(bus.m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("s_ready_up", 32'(bus.s_ready), 32'd1);

    // Bytes 0..135, results k*0x01010101.
    full_frame(8'h00, 1'b0, 1'b0, 2, 1'b0, -1, 32'h0);
    // Toggling source, spurious o_valid in SEND_I, w_ready on first WAIT_W cycle,
    // gap in the result stream, sink stall on word 3.
    full_frame(8'h55, 1'b1, 1'b1, 0, 1'b1, 3, 32'hA500_0000);

    // Weight handshake never arrives.
    chk("err_pre", 32'(err), 32'd0);
    load_frame(8'hC0, 1'b0, c);
    send_i(1'b0, n);
    n = 0;
    while (busy === 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", 32'(n), 32'd1024);
    chk("to_err", 32'(err), 32'd1);
    chk("to_s_ready", 32'(bus.s_ready), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);

    // Reset in the middle of the input stream.
    load_frame(8'h40, 1'b0, c);
    n = 1;
    while (n < 60 && bus.i_valid === 1'b1) begin
      @(negedge clk);
      if (bus.i_valid === 1'b1) n++;
    end
    chk("mid_i_count", 32'(n), 32'd60);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_i_valid", 32'(bus.i_valid), 32'd0);
    chk("mid_err", 32'(err), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_s_ready", 32'(bus.s_ready), 32'd0);
    iq.delete();
    wq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_s_ready", 32'(bus.s_ready), 32'd1);

    full_frame(8'h20, 1'b0, 1'b0, 1, 1'b0, 7, 32'h0000_5A5A);
    chk("final_err", 32'(err), 32'd0);
    chk("iq_empty", 32'(iq.size()), 32'd0);
    chk("wq_empty", 32'(wq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
